// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: ALU op encodings, forwarding
// source select and the EX register payload layout.
package alu_pkg;

  localparam int ALU_D_WIDTH = 32;
  localparam int ALU_A_WIDTH = 5;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLT = 3'b100
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    REG = 2'd0,
    MEM = 2'd1,
    WB  = 2'd2
  } fwd_sel_e;

  // ctrl is kept as raw bits so undefined encodings pass through untouched
  typedef struct packed {
    logic [2:0]             ctrl;
    logic [ALU_A_WIDTH-1:0] rs1;
    logic [ALU_A_WIDTH-1:0] rs2;
    logic [ALU_A_WIDTH-1:0] rd;
    logic [ALU_D_WIDTH-1:0] data1;
    logic [ALU_D_WIDTH-1:0] data2;
    logic [ALU_D_WIDTH-1:0] imm;
    logic                   alu_src;
    logic                   reg_write;
    logic                   mem_read;
  } ex_payload_t;

endpackage

// File: rtl/alu_fwd_unit.sv
// Operand forwarding select for one source register. EX/MEM result has
// priority over MEM/WB; x0 always reads the stored register data.
module alu_fwd_unit
  import alu_pkg::*;
#(
  parameter int D_WIDTH = ALU_D_WIDTH,
  parameter int A_WIDTH = ALU_A_WIDTH
) (
  input  logic [A_WIDTH-1:0] rs,
  input  logic [D_WIDTH-1:0] reg_data,
  input  logic [A_WIDTH-1:0] mem_rd,
  input  logic               mem_reg_write,
  input  logic [D_WIDTH-1:0] mem_result,
  input  logic [A_WIDTH-1:0] wb_rd,
  input  logic               wb_reg_write,
  input  logic [D_WIDTH-1:0] wb_result,
  output logic [D_WIDTH-1:0] data
);

  fwd_sel_e sel;

  // pick the youngest in-flight producer of rs
  always_comb begin
    sel = REG;
    if (mem_reg_write && (mem_rd == rs) && (rs != '0))
      sel = MEM;
    else if (wb_reg_write && (wb_rd == rs) && (rs != '0))
      sel = WB;
  end

  // operand mux
  always_comb begin
    case (sel)
      MEM:     data = mem_result;
      WB:      data = wb_result;
      default: data = reg_data;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register in front of the ALU with MEM/WB forwarding, load-use
// bubble insertion and flush.
// Optional: define ALU_ISSUE_STALL_CNT_EN to add the saturating stall_cnt
// output (cycles where decode presented an instruction that was refused).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int D_WIDTH = ALU_D_WIDTH,
  parameter int A_WIDTH = ALU_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [2:0]         id_alu_ctrl,
  input  logic [A_WIDTH-1:0] id_rs1,
  input  logic [A_WIDTH-1:0] id_rs2,
  input  logic [A_WIDTH-1:0] id_rd,
  input  logic [D_WIDTH-1:0] id_rs1_data,
  input  logic [D_WIDTH-1:0] id_rs2_data,
  input  logic [D_WIDTH-1:0] id_imm,
  input  logic               id_alu_src,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [2:0]         ALUctrl,
  output logic [D_WIDTH-1:0] ALUop1,
  output logic [D_WIDTH-1:0] ALUop2,
  output logic [A_WIDTH-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
`ifdef ALU_ISSUE_STALL_CNT_EN
  output logic [31:0]        stall_cnt,
`endif
  input  logic [A_WIDTH-1:0] mem_rd,
  input  logic               mem_reg_write,
  input  logic [D_WIDTH-1:0] mem_result,
  input  logic [A_WIDTH-1:0] wb_rd,
  input  logic               wb_reg_write,
  input  logic [D_WIDTH-1:0] wb_result
);

  ex_payload_t              ex_q;
  logic                     hz;
  logic                     accept;
  logic [D_WIDTH-1:0]       fwd1;
  logic [D_WIDTH-1:0]       fwd2;

  // a load in EX cannot forward its data in time; rs2 only matters when used
  assign hz = ex_valid & ex_q.mem_read & (ex_q.rd != '0) &
              ((id_rs1 == ex_q.rd) | (~id_alu_src & (id_rs2 == ex_q.rd)));

  assign id_ready = (~ex_valid | ex_ready) & ~hz & ~flush;
  assign accept   = id_valid & id_ready;

  // EX register: flush, then transfer, then bubble, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (flush) begin
      ex_valid       <= 1'b0;
      ex_q.reg_write <= 1'b0;
      ex_q.mem_read  <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_q     <= '{ctrl:      id_alu_ctrl,
                    rs1:       id_rs1,
                    rs2:       id_rs2,
                    rd:        id_rd,
                    data1:     id_rs1_data,
                    data2:     id_rs2_data,
                    imm:       id_imm,
                    alu_src:   id_alu_src,
                    reg_write: id_reg_write,
                    mem_read:  id_mem_read};
    end else if (ex_ready) begin
      ex_valid       <= 1'b0;
      ex_q.reg_write <= 1'b0;
      ex_q.mem_read  <= 1'b0;
    end
  end

  alu_fwd_unit #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_fwd1 (
    .rs            (ex_q.rs1),
    .reg_data      (ex_q.data1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .data          (fwd1)
  );

  alu_fwd_unit #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_fwd2 (
    .rs            (ex_q.rs2),
    .reg_data      (ex_q.data2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .data          (fwd2)
  );

  assign ALUctrl      = ex_q.ctrl;
  assign ALUop1       = fwd1;
  assign ALUop2       = ex_q.alu_src ? ex_q.imm : fwd2;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;

`ifdef ALU_ISSUE_STALL_CNT_EN
  // count refused decode cycles, sticking at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (id_valid && !id_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: reset, issue, forwarding,
// load-use bubble, flush, back-pressure and async reset mid-stream.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  id_alu_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src, id_reg_write, id_mem_read;
  logic        flush, ex_ready;
  logic        ex_valid;
  logic [2:0]  ALUctrl;
  logic [31:0] ALUop1, ALUop2;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
`ifdef ALU_ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_alu_ctrl   (id_alu_ctrl),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .id_imm        (id_imm),
    .id_alu_src    (id_alu_src),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .flush         (flush),
    .ex_ready      (ex_ready),
    .ex_valid      (ex_valid),
    .ALUctrl       (ALUctrl),
    .ALUop1        (ALUop1),
    .ALUop2        (ALUop2),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
`ifdef ALU_ISSUE_STALL_CNT_EN
    .stall_cnt     (stall_cnt),
`endif
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] ctrl,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic src, input logic rw, input logic mr);
    id_valid     = v;
    id_alu_ctrl  = ctrl;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_rs1_data  = d1;
    id_rs2_data  = d2;
    id_imm       = imm;
    id_alu_src   = src;
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic clear_fwd();
    mem_rd = '0; mem_reg_write = 1'b0; mem_result = '0;
    wb_rd  = '0; wb_reg_write  = 1'b0; wb_result  = '0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    ex_ready = 1'b1;
    set_id(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    clear_fwd();
    tick();
    tick();

    // reset state
    check("rst_ex_valid", ex_valid, 0);
    check("rst_aluctrl", ALUctrl, 0);
    check("rst_op1", ALUop1, 0);
    check("rst_op2", ALUop2, 0);
    check("rst_ex_rd", ex_rd, 0);
    check("rst_ex_rw", ex_reg_write, 0);
    check("rst_ex_mr", ex_mem_read, 0);
    rst = 1'b0;
    #1;
    check("idle_id_ready", id_ready, 1);

    // add x6 = x1(5) + imm 7
    set_id(1'b1, 3'b000, 5'd1, 5'd2, 5'd6, 32'd5, 32'd9, 32'd7, 1'b1, 1'b1, 1'b0);
    tick();
    check("add_ex_valid", ex_valid, 1);
    check("add_op1", ALUop1, 32'd5);
    check("add_op2_imm", ALUop2, 32'd7);
    check("add_ctrl", ALUctrl, 3'b000);
    check("add_ex_rd", ex_rd, 5'd6);
    check("add_ex_rw", ex_reg_write, 1);

    // sub x7 = x3(0x33) - x4(0x44), back to back
    set_id(1'b1, 3'b001, 5'd3, 5'd4, 5'd7, 32'h33, 32'h44, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    check("sub_op1", ALUop1, 32'h33);
    check("sub_op2", ALUop2, 32'h44);
    check("sub_ctrl", ALUctrl, 3'b001);

    // hold EX and let producers arrive late
    id_valid = 1'b0;
    ex_ready = 1'b0;
    mem_rd = 5'd3; mem_reg_write = 1'b1; mem_result = 32'h10;
    wb_rd  = 5'd3; wb_reg_write  = 1'b1; wb_result  = 32'h20;
    #1;
    check("held_id_ready", id_ready, 0);
    check("fwd_mem_prio", ALUop1, 32'h10);
    mem_reg_write = 1'b0;
    #1;
    check("fwd_wb", ALUop1, 32'h20);
    wb_rd = 5'd4;
    #1;
    check("fwd_wb_rs2_op1", ALUop1, 32'h33);
    check("fwd_wb_rs2", ALUop2, 32'h20);
    mem_rd = 5'd4; mem_reg_write = 1'b1;
    #1;
    check("fwd_mem_rs2", ALUop2, 32'h10);
    clear_fwd();
    ex_ready = 1'b1;

    // x0 is never forwarded
    set_id(1'b1, 3'b010, 5'd0, 5'd0, 5'd9, 32'h55, 32'h66, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    id_valid = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'h10;
    wb_rd  = 5'd0; wb_reg_write  = 1'b1; wb_result  = 32'h20;
    #1;
    check("x0_op1", ALUop1, 32'h55);
    check("x0_op2", ALUop2, 32'h66);
    check("and_ctrl", ALUctrl, 3'b010);
    clear_fwd();

    // undefined op passes through; immediate is not forwarded, rs1 is
    set_id(1'b1, 3'b111, 5'd5, 5'd5, 5'd10, 32'h1, 32'h2, 32'h77, 1'b1, 1'b0, 1'b0);
    tick();
    id_valid = 1'b0;
    mem_rd = 5'd5; mem_reg_write = 1'b1; mem_result = 32'h10;
    #1;
    check("ctrl_passthru", ALUctrl, 3'b111);
    check("imm_no_fwd", ALUop2, 32'h77);
    check("imm_rs1_fwd", ALUop1, 32'h10);
    clear_fwd();

    // load x4, then a consumer of x4
    set_id(1'b1, 3'b000, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 1'b1);
    tick();
    check("ld_ex_mr", ex_mem_read, 1);
    set_id(1'b1, 3'b011, 5'd4, 5'd5, 5'd8, 32'hAA, 32'hBB, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    check("hz_id_ready", id_ready, 0);
    tick();
    check("bubble_ex_valid", ex_valid, 0);
    check("bubble_ex_rw", ex_reg_write, 0);
    check("bubble_ex_mr", ex_mem_read, 0);
    check("bubble_rd_kept", ex_rd, 5'd4);
    check("after_bubble_ready", id_ready, 1);
    tick();
    id_valid = 1'b0;
    check("hz_accept_valid", ex_valid, 1);
    check("hz_accept_ctrl", ALUctrl, 3'b011);
    check("hz_accept_rd", ex_rd, 5'd8);
    check("hz_accept_op1", ALUop1, 32'hAA);
    check("hz_accept_op2", ALUop2, 32'hBB);
`ifdef ALU_ISSUE_STALL_CNT_EN
    check("stall_cnt_hz", stall_cnt, 32'd1);
`endif

    // flush while decode presents an instruction
    set_id(1'b1, 3'b000, 5'd2, 5'd3, 5'd13, 32'h9, 32'h9, 32'h0, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_id_ready", id_ready, 0);
    tick();
    flush = 1'b0;
    id_valid = 1'b0;
    check("flush_ex_valid", ex_valid, 0);
    check("flush_no_xfer_rd", ex_rd, 5'd8);

    // slt x11, then back-pressure for 3 cycles with next op waiting
    set_id(1'b1, 3'b100, 5'd9, 5'd10, 5'd11, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'b001, 5'd9, 5'd10, 5'd12, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1'b0);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_id_ready", id_ready, 0);
      tick();
      check("stall_valid", ex_valid, 1);
      check("stall_ctrl", ALUctrl, 3'b100);
      check("stall_op1", ALUop1, 32'h1234);
      check("stall_op2", ALUop2, 32'h5678);
      check("stall_rd", ex_rd, 5'd11);
    end
    ex_ready = 1'b1;
    #1;
    check("resume_id_ready", id_ready, 1);
    tick();
    id_valid = 1'b0;
    check("resume_rd", ex_rd, 5'd12);
    check("resume_ctrl", ALUctrl, 3'b001);
`ifdef ALU_ISSUE_STALL_CNT_EN
    check("stall_cnt_total", stall_cnt, 32'd5);
`endif

    // asynchronous reset with a live instruction in EX
    set_id(1'b1, 3'b011, 5'd7, 5'd8, 5'd14, 32'hDEAD, 32'hBEEF, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    id_valid = 1'b0;
    check("pre_rst_valid", ex_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", ex_valid, 0);
    check("mid_rst_op1", ALUop1, 0);
    check("mid_rst_op2", ALUop2, 0);
    check("mid_rst_ctrl", ALUctrl, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX pipeline stage sitting directly upstream of the ALU. It accepts one decoded instruction per valid/ready handshake and holds the operands, rd and control bits in the EX register. It drives ALUctrl/ALUop1/ALUop2 with MEM/WB operand forwarding applied, and inserts a bubble on load-use hazards and flushes.

Parameters:
D_WIDTH, 32, datapath width.
A_WIDTH, 5, register-index width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  decode presents an instruction
id_ready  out  1  stage accepts the instruction this cycle
id_alu_ctrl  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 slt
id_rs1, id_rs2, id_rd  in  A_WIDTH each  register indices
id_rs1_data, id_rs2_data, id_imm  in  D_WIDTH each  register-file reads and immediate
id_alu_src  in  1  0: op2 = rs2, 1: op2 = imm
id_reg_write, id_mem_read  in  1 each  writes rd; is a load
flush  in  1  kill EX contents (branch taken)
ex_ready  in  1  ALU/EX-MEM can take the EX instruction
ex_valid  out  1  EX register holds a live instruction
ALUctrl  out  3  to ALU
ALUop1, ALUop2  out  D_WIDTH  to ALU, forwarded
ex_rd  out  A_WIDTH; ex_reg_write, ex_mem_read  out  1 each
mem_rd  in  A_WIDTH; mem_reg_write  in 1; mem_result  in D_WIDTH  EX/MEM producer
wb_rd  in  A_WIDTH; wb_reg_write  in 1; wb_result  in D_WIDTH  MEM/WB producer

Behaviour:
- Reset (async, rst=1):
  - ex_valid=0, all stored fields=0.
  - Outputs therefore read ALUctrl=0, ALUop1=ALUop2=0, ex_rd=0, ex_reg_write=0, ex_mem_read=0.
- Hazard: hz = ex_valid & ex_mem_read & ex_rd!=0 & (id_rs1==ex_rd | (!id_alu_src & id_rs2==ex_rd)).
- id_ready = (!ex_valid | ex_ready) & !hz & !flush.
- Clock edge, in priority order:
  - flush: ex_valid<=0.
  - else if id_valid & id_ready: load all fields, ex_valid<=1.
  - else if ex_ready: ex_valid<=0 (bubble; on a hazard exactly one bubble is issued).
  - else hold all fields.
- Latency: 1 cycle ID to EX. Full throughput when ex_ready=1 and no hazard.
- Stored fields (rd, ctrl, operands) are written only on an accepted transfer. Bubbles clear only ex_valid, ex_reg_write and ex_mem_read.
- Forwarding: combinational on the stored EX rs1/rs2 each cycle, so results that arrive while EX is held are still picked up.
  - src = MEM if mem_reg_write & mem_rd==rs & rs!=0.
  - else WB if wb_reg_write & wb_rd==rs & rs!=0.
  - else the stored register data. MEM has priority over WB.
- ALUop1 = fwd(rs1).
- ALUop2 = stored imm if stored alu_src=1; else fwd(rs2). The immediate is never forwarded.
- Register x0 is never forwarded.
- ALUctrl values outside 000–100 pass through unchanged.
- flush and a hazard in the same cycle: flush wins, no transfer.
- ex_ready=0 with ex_valid=1: EX held and stable, id_ready=0.

Optional Feature:
- Macro: ALU_ISSUE_STALL_CNT_EN.
- When defined, the block adds output stall_cnt (32 bits).
  - Increments each cycle id_valid=1 and id_ready=0.
  - Saturates at all-ones.
  - Reset to 0.
- When undefined, the port and counter are absent and the block is functionally identical otherwise.

Decomposition:
- Package alu_pkg holds:
  - alu_ctrl_e enum: ADD=000, SUB=001, AND=010, OR=011, SLT=100.
  - fwd_sel_e enum: REG, MEM, WB.
  - ex_payload_t struct: ctrl, rs1, rs2, rd, data1, data2, imm, alu_src, reg_write, mem_read.
- One sub-module, alu_fwd_unit: combinational forwarding select, instantiated once per source operand.

Test Plan:
- Reset mid-stream with ex_valid=1 → next sample ex_valid=0, ALUop1=0, ALUop2=0, ALUctrl=0.
- Issue add, rs1=1 (data 5), imm=7, alu_src=1 → next cycle ALUop1=5, ALUop2=7, ALUctrl=000, ex_valid=1.
- EX rs1=3; mem_rd=3 with mem_result=0x10, wb_rd=3 with wb_result=0x20, both writing → ALUop1=0x10. Same with rs1=0 → ALUop1 = stored data.
- Load to x4 in EX, next ID reads x4 → id_ready=0 for one cycle, one bubble (ex_valid=0), then ID accepted; with the feature enabled, stall_cnt=1.
- flush=1 while id_valid=1 → no transfer, ex_valid=0 next cycle.
- ex_ready=0 for 3 cycles → ALUctrl, ALUop and ex_rd stable, id_ready=0; resumes when ex_ready=1.
